serial_deserializer: RTL and testbench

- Asynchronous-serial receiver: recovers 8-bit bytes from a single-wire line (idle high, 1 start bit low, 8 data bits LSB first, 1 stop bit high).
- Sits directly downstream of the serializer and upstream of the byte checker/consumer.
- Presents each byte on `data` with a one-cycle `received` strobe; the consumer may trigger on the rising edge of `received`.

---
 rtl/serial_deserializer.sv | 210 +++++++++++++++++++++
 tb/tb_serial_deserializer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Asynchronous-serial receiver. It recovers 8-bit bytes from a single-wire
// line. The frame is: idle high, one start bit (low), eight data bits sent
// LSB first, then one stop bit (high).
//
// Optional feature, selected by the macro SERIAL_DESERIALIZER_PARITY_EN:
//   - An even-parity bit follows data bit 7 and comes before the stop bit.
//   - A PARITY state samples that bit.
//   - The port parity_err is added.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit. Must be >= 4.
//   CNT_W        : width of the bit-period counter. 2**CNT_W must exceed
//                  CLKS_PER_BIT.
//
// Ports:
//   clk        in   system clock. All state updates on the rising edge.
//   rst        in   asynchronous, active-high reset.
//   rx         in   serial line. Asynchronous to clk, idle high.
//   data       out  last good byte. Held until the next byte completes.
//   received   out  one-cycle strobe. data is valid in the same cycle.
//   frame_err  out  one-cycle strobe. The stop bit was sampled low.
//   busy       out  high from start-bit detection until return to IDLE.
//   parity_err out  (parity build only) one-cycle strobe in the stop-sample
//                   cycle when the data bits XOR the parity bit is non-zero.
//
// Handshake: there is no backpressure. received and frame_err are
// valid-only pulses, one clock wide, and are never high together. The
// consumer must take data in the cycle that received is high, or at any
// later time before the next received pulse.
// -----------------------------------------------------------------------------
module serial_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       received,
    output logic       frame_err,
    output logic       busy
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Terminal counts. START waits half a bit so that every later sample
    // falls near the middle of its bit.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             received_q, received_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_meta_q, rx_s_q;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
    logic             parity_err_q, parity_err_d;
`endif

    // Two-flop synchronizer. It resets to the idle level so that a reset
    // cannot fake a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            received_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            received_q   <= received_d;
            frame_err_q  <= frame_err_d;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        received_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    // A high line at mid-start-bit is a glitch, not a frame.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    // Shift in from the top. After eight samples, the first
                    // sample sits in bit 0 (LSB first).
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    parity_d = rx_s_q;
                    state_d  = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop-bit. This gives time to catch a start bit
                // that follows the stop bit with no idle gap.
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        data_d     = shift_q;
                        received_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    parity_err_d = (^shift_q) ^ parity_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign received  = received_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//
// Directed testbench for serial_deserializer with CLKS_PER_BIT = 16.
//
// How stimulus is driven:
//   - The serial line is driven on falling clock edges.
//   - The watch task samples DUT outputs on falling clock edges. Each scenario
//     runs watch in parallel with the driver.
//
// Expected values:
//   - Bytes and timing are hand-computed from the frame format.
//   - The fixed latency is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles.
//   - The parity build adds CLKS_PER_BIT to that latency.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

    localparam int CPB = 16;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;
    localparam int LAT       = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       received;
    logic       frame_err;
    logic       busy;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic       parity_err;
    logic       par_flip_g;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_deserializer #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .received  (received),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    // ---------------- scoreboard state ----------------
    int         vectors;
    int         miscompares;
    logic [7:0] exp_q[$];
    logic [7:0] last_data;

    // Results collected by watch().
    logic [7:0] got_q[$];
    int         got_t[$];
    int         ferr_n;
    int         ferr_t;
    int         both_n;
    int         wide_n;
    int         busy_hi_n;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    int         perr_n;
    int         perr_t;
`endif

    // ---------------- driver tasks ----------------
    // Drive one complete frame. rx is left at the stop-bit level so that
    // the caller can start the next frame with no gap.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        rx = (^b) ^ par_flip_g;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // Sample outputs for ncyc falling edges. Cycle index c counts from 1 at
    // the first falling edge after the call.
    task automatic watch(input int ncyc);
        logic prev_rcv;
        got_q.delete();
        got_t.delete();
        ferr_n    = 0;
        ferr_t    = -1;
        both_n    = 0;
        wide_n    = 0;
        busy_hi_n = 0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        perr_n = 0;
        perr_t = -1;
`endif
        prev_rcv = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (received === 1'b1) begin
                got_q.push_back(data);
                got_t.push_back(c);
                if (prev_rcv) wide_n++;
            end
            if (frame_err === 1'b1) begin
                ferr_n++;
                ferr_t = c;
            end
            if (received === 1'b1 && frame_err === 1'b1) both_n++;
            if (busy === 1'b1) busy_hi_n++;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            if (parity_err === 1'b1) begin
                perr_n++;
                perr_t = c;
            end
`endif
            prev_rcv = (received === 1'b1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({data, received, frame_err, busy} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_hold: data=%h rcv=%b ferr=%b busy=%b, expected all zero",
                         data, received, frame_err, busy);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            vectors++;
            if ({data, received, frame_err, busy} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: data=%h rcv=%b ferr=%b busy=%b, expected all zero",
                         i, data, received, frame_err, busy);
            end
        end
        last_data = 8'h00;
    endtask

    task automatic test_single();
        logic [7:0] g0;
        int         lat;
        fork
            drive_frame(8'hA5, 1'b1);
            watch(LAT + 40);
        join
        g0  = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        lat = (got_t.size() > 0) ? got_t[0] - 1 : -1;
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d pulses, expected 1", got_q.size());
        end
        vectors++;
        if (g0 !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_data: got %h, expected a5", g0);
        end
        vectors++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            miscompares++;
            $display("FAIL single_latency: got %0d, expected %0d +/-1", lat, LAT);
        end
        vectors++;
        if (wide_n != 0 || ferr_n != 0 || both_n != 0) begin
            miscompares++;
            $display("FAIL single_strobes: wide=%0d ferr=%0d both=%0d, expected 0 0 0",
                     wide_n, ferr_n, both_n);
        end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        vectors++;
        if (perr_n != 0) begin
            miscompares++;
            $display("FAIL single_parity_err: got %0d pulses, expected 0", perr_n);
        end
`endif
        vectors++;
        if (data !== 8'hA5 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_hold: data=%h busy=%b, expected a5 0", data, busy);
        end
        last_data = 8'hA5;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [7:0] g;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        fork
            begin
                drive_frame(8'h00, 1'b1);
                drive_frame(8'hFF, 1'b1);
                drive_frame(8'h55, 1'b1);
                rx = 1'b1;
            end
            watch(3 * FRAME_CYC + 40);
        join
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d pulses, expected 3", got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL b2b_data: got %h, expected %h", g, e);
            end
        end
        vectors++;
        if (got_t.size() == 3 && (got_t[1] - got_t[0] != FRAME_CYC || got_t[2] - got_t[1] != FRAME_CYC)) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d and %0d cycles, expected %0d",
                     got_t[1] - got_t[0], got_t[2] - got_t[1], FRAME_CYC);
        end
        vectors++;
        if (ferr_n != 0 || wide_n != 0 || both_n != 0) begin
            miscompares++;
            $display("FAIL b2b_strobes: ferr=%0d wide=%0d both=%0d, expected 0 0 0",
                     ferr_n, wide_n, both_n);
        end
        vectors++;
        if (data !== 8'h55) begin
            miscompares++;
            $display("FAIL b2b_final_data: got %h, expected 55", data);
        end
        last_data = 8'h55;
    endtask

    task automatic test_glitch();
        repeat (10) @(negedge clk);
        fork
            begin
                rx = 1'b0;
                repeat (4) @(negedge clk);
                rx = 1'b1;
            end
            watch(40);
        join
        // busy is high from start detection until the mid-start-bit sample,
        // which is half a bit period.
        vectors++;
        if (busy_hi_n != CPB / 2) begin
            miscompares++;
            $display("FAIL glitch_busy_cycles: got %0d, expected %0d", busy_hi_n, CPB / 2);
        end
        vectors++;
        if (got_q.size() != 0 || ferr_n != 0) begin
            miscompares++;
            $display("FAIL glitch_strobes: rcv=%0d ferr=%0d, expected 0 0", got_q.size(), ferr_n);
        end
        vectors++;
        if (busy !== 1'b0 || data !== last_data) begin
            miscompares++;
            $display("FAIL glitch_idle: busy=%b data=%h, expected 0 %h", busy, data, last_data);
        end
    endtask

    task automatic test_frame_err();
        fork
            begin
                drive_frame(8'h3C, 1'b0);
                rx = 1'b1;
                repeat (2 * CPB) @(negedge clk);
            end
            watch(FRAME_CYC + 2 * CPB);
        join
        vectors++;
        if (ferr_n != 1) begin
            miscompares++;
            $display("FAIL ferr_count: got %0d pulses, expected 1", ferr_n);
        end
        vectors++;
        if (ferr_t - 1 < LAT - 1 || ferr_t - 1 > LAT + 1) begin
            miscompares++;
            $display("FAIL ferr_time: got %0d, expected %0d +/-1", ferr_t - 1, LAT);
        end
        vectors++;
        if (got_q.size() != 0 || data !== last_data || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ferr_no_update: rcv=%0d data=%h busy=%b, expected 0 %h 0",
                     got_q.size(), data, last_data, busy);
        end
        fork
            drive_frame(8'h81, 1'b1);
            watch(LAT + 40);
        join
        vectors++;
        if (got_q.size() != 1 || data !== 8'h81 || ferr_n != 0) begin
            miscompares++;
            $display("FAIL ferr_recover: rcv=%0d data=%h ferr=%0d, expected 1 81 0",
                     got_q.size(), data, ferr_n);
        end
        last_data = 8'h81;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h5A;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy_before: got %b, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({data, received, frame_err, busy} !== 11'd0) begin
            miscompares++;
            $display("FAIL rstmid_immediate: data=%h rcv=%b ferr=%b busy=%b, expected all zero",
                     data, received, frame_err, busy);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        watch(2 * CPB);
        vectors++;
        if (got_q.size() != 0 || ferr_n != 0 || busy_hi_n != 0 || data !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_quiet: rcv=%0d ferr=%0d busy=%0d data=%h, expected 0 0 0 00",
                     got_q.size(), ferr_n, busy_hi_n, data);
        end
        fork
            drive_frame(8'h7E, 1'b1);
            watch(LAT + 40);
        join
        vectors++;
        if (got_q.size() != 1 || data !== 8'h7E || ferr_n != 0) begin
            miscompares++;
            $display("FAIL rstmid_recover: rcv=%0d data=%h ferr=%0d, expected 1 7e 0",
                     got_q.size(), data, ferr_n);
        end
        last_data = 8'h7E;
    endtask

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    task automatic test_parity();
        int t0;
        par_flip_g = 1'b1;
        fork
            drive_frame(8'h07, 1'b1);
            watch(LAT + 40);
        join
        par_flip_g = 1'b0;
        t0 = (got_t.size() > 0) ? got_t[0] : -2;
        vectors++;
        if (got_q.size() != 1 || data !== 8'h07) begin
            miscompares++;
            $display("FAIL parity_data: rcv=%0d data=%h, expected 1 07", got_q.size(), data);
        end
        vectors++;
        if (perr_n != 1 || perr_t != t0) begin
            miscompares++;
            $display("FAIL parity_err: pulses=%0d at %0d, expected 1 at %0d", perr_n, perr_t, t0);
        end
        last_data = 8'h07;
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx          = 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        par_flip_g  = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
